// File: rtl/fp32_divider_seq_if.sv
// Start/busy/done handshake bundle for the sequential FP32 divider.
// master drives start, A, B; slave returns busy, done, S.
interface fp32_divider_seq_if;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] S;

    modport master (
        output start, A, B,
        input  busy, done, S
    );

    modport slave (
        input  start, A, B,
        output busy, done, S
    );
endinterface

// File: rtl/fp32_divider_seq.sv
// Sequential FP32 divider S = A / B, restoring, one quotient bit per clock.
// Ports: clk, rst_n (sync, active-low), bus (slave: start/A/B in, busy/done/S out).
module fp32_divider_seq (
    input  logic                 clk,
    input  logic                 rst_n,
    fp32_divider_seq_if.slave    bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] NORM = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  ea_q, ea_d;
    logic [7:0]  eb_q, eb_d;
    logic [24:0] rem_q, rem_d;
    logic [23:0] div_q, div_d;
    logic [24:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        spec_q, spec_d;
    logic [31:0] sres_q, sres_d;
    logic [31:0] s_q, s_d;

    // Operand classification on the live inputs, used only at acceptance.
    logic        sgn;
    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;
    logic        is_nan, is_inf, is_zero;
    logic [31:0] spec_val;

    assign sgn    = bus.A[31] ^ bus.B[31];
    assign a_zero = bus.A[30:23] == 8'h00;
    assign b_zero = bus.B[30:23] == 8'h00;
    assign a_inf  = bus.A[30:23] == 8'hFF && bus.A[22:0] == 23'd0;
    assign b_inf  = bus.B[30:23] == 8'hFF && bus.B[22:0] == 23'd0;
    assign a_nan  = bus.A[30:23] == 8'hFF && bus.A[22:0] != 23'd0;
    assign b_nan  = bus.B[30:23] == 8'hFF && bus.B[22:0] != 23'd0;

    assign is_nan  = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
    assign is_inf  = a_inf | b_zero;
    assign is_zero = a_zero | b_inf;

    always_comb begin
        spec_val = {sgn, 31'd0};
        if (is_nan)
            spec_val = 32'h7FC00000;
        else if (is_inf)
            spec_val = {sgn, 8'hFF, 23'd0};
    end

    // One restoring step; the difference always fits in 24 bits.
    logic        rem_ge;
    logic [24:0] rem_sub;

    assign rem_ge  = rem_q >= {1'b0, div_q};
    assign rem_sub = rem_ge ? rem_q - {1'b0, div_q} : rem_q;

    // Biased exponent in 10-bit two's complement, minus one when q < 1.0.
    logic [9:0]  exp_n;
    logic [22:0] frac_n;
    logic        ovf, unf;
    logic [31:0] norm_res;

    assign exp_n  = {2'b00, ea_q} - {2'b00, eb_q} + 10'd127
                  - {9'd0, ~quo_q[24]};
    assign frac_n = quo_q[24] ? quo_q[23:1] : quo_q[22:0];
    assign ovf    = ~exp_n[9] && exp_n >= 10'd255;
    assign unf    = exp_n[9] || exp_n == 10'd0;

    always_comb begin
        norm_res = {sign_q, exp_n[7:0], frac_n};
        if (ovf)
            norm_res = {sign_q, 8'hFF, 23'd0};
        else if (unf)
            norm_res = {sign_q, 31'd0};
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        spec_d  = spec_q;
        sres_d  = sres_q;
        s_d     = s_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sign_d  = sgn;
                    ea_d    = bus.A[30:23];
                    eb_d    = bus.B[30:23];
                    rem_d   = {2'b01, bus.A[22:0]};
                    div_d   = {1'b1, bus.B[22:0]};
                    quo_d   = 25'd0;
                    cnt_d   = 5'd0;
                    spec_d  = is_nan | is_inf | is_zero;
                    sres_d  = spec_val;
                    state_d = (is_nan | is_inf | is_zero) ? NORM : CALC;
                end
            end
            CALC: begin
                rem_d = {rem_sub[23:0], 1'b0};
                quo_d = {quo_q[23:0], rem_ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd24)
                    state_d = NORM;
            end
            NORM: begin
                s_d     = spec_q ? sres_q : norm_res;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            ea_q    <= 8'd0;
            eb_q    <= 8'd0;
            rem_q   <= 25'd0;
            div_q   <= 24'd0;
            quo_q   <= 25'd0;
            cnt_q   <= 5'd0;
            spec_q  <= 1'b0;
            sres_q  <= 32'd0;
            s_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            spec_q  <= spec_d;
            sres_q  <= sres_d;
            s_q     <= s_d;
        end
    end

    assign bus.busy = (state_q == CALC) || (state_q == NORM);
    assign bus.done = state_q == DONE;
    assign bus.S    = s_q;

endmodule

// File: tb/tb_fp32_divider_seq.sv
// Self-checking bench for fp32_divider_seq: vector table, random ops
// against an arithmetic reference, handshake and reset sequences.
module tb_fp32_divider_seq;

    logic clk;
    logic rst_n;
    int   cyc;
    int   vecs;
    int   miss;

    fp32_divider_seq_if bus ();

    fp32_divider_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain integer quotient of the significands, then IEEE packing.
    function automatic logic [31:0] ref_div(input logic [31:0] a,
                                            input logic [31:0] b,
                                            output bit special);
        bit          sg;
        int          ea, eb, e;
        bit          az, bz, ai, bi, an, bn;
        longint unsigned ma, mb, q;
        logic [22:0] fr;
        sg = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        az = ea == 0;
        bz = eb == 0;
        ai = ea == 255 && a[22:0] == 0;
        bi = eb == 255 && b[22:0] == 0;
        an = ea == 255 && a[22:0] != 0;
        bn = eb == 255 && b[22:0] != 0;
        special = 1'b1;
        if (an || bn || (az && bz) || (ai && bi))
            return 32'h7FC00000;
        if (ai || bz)
            return {sg, 8'hFF, 23'd0};
        if (az || bi)
            return {sg, 31'd0};
        special = 1'b0;
        ma = 64'h800000 + longint'(a[22:0]);
        mb = 64'h800000 + longint'(b[22:0]);
        q  = (ma << 24) / mb;
        e  = ea - eb + 127;
        if (q >= 64'h1000000) begin
            fr = 23'((q >> 1) & 64'h7FFFFF);
        end else begin
            fr = 23'(q & 64'h7FFFFF);
            e  = e - 1;
        end
        if (e >= 255)
            return {sg, 8'hFF, 23'd0};
        if (e <= 0)
            return {sg, 31'd0};
        return {sg, 8'(e), fr};
    endfunction

    // Issue one op in the current cycle; report latency in cycles to done.
    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] s, output int lat);
        int c0;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        c0        = cyc;
        lat       = -1;
        s         = 32'hx;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = cyc - c0;
                s   = bus.S;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_op();
        int r;
        r = $urandom_range(0, 11);
        if (r == 0)
            return {1'($urandom), 8'h00, 23'($urandom)};
        if (r == 1)
            return {1'($urandom), 8'hFF, 23'd0};
        if (r == 2)
            return {1'($urandom), 8'hFF, 23'($urandom) | 23'd1};
        return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    logic [31:0] s;
    logic [31:0] exp_s;
    int          lat;
    bit          sp;
    int          berr;
    int          nd;
    int          d1;
    int          d2;
    logic [31:0] s27;
    logic [31:0] s40;
    logic [31:0] s55;

    initial begin
        vecs      = 0;
        miss      = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;

        tbl[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 27};
        tbl[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27};
        tbl[2] = '{32'hC0000000, 32'h3F000000, 32'hC0800000, 27};
        tbl[3] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 2};
        tbl[4] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 2};
        tbl[5] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 2};
        tbl[6] = '{32'h40000000, 32'h7F800000, 32'h00000000, 2};
        tbl[7] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 27};
        tbl[8] = '{32'h00800000, 32'h40000000, 32'h00000000, 27};
        tbl[9] = '{32'h7FC12345, 32'h3F800000, 32'h7FC00000, 2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset S", bus.S, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (tbl[i]) begin
            run(tbl[i].a, tbl[i].b, s, lat);
            chk($sformatf("tbl%0d S", i), s, tbl[i].s);
            chk_i($sformatf("tbl%0d lat", i), lat, tbl[i].lat);
        end

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a     = rnd_op();
            b     = rnd_op();
            exp_s = ref_div(a, b, sp);
            run(a, b, s, lat);
            chk($sformatf("rnd%0d %h/%h S", i, a, b), s, exp_s);
            chk_i($sformatf("rnd%0d lat", i), lat, sp ? 2 : 27);
        end

        // Busy window, ignored start while busy, back-to-back start.
        berr = 0;
        nd   = 0;
        d1   = -1;
        d2   = -1;
        s27  = 32'h0;
        s40  = 32'h0;
        s55  = 32'h0;
        bus.A     = 32'h40C00000;
        bus.B     = 32'h40000000;
        bus.start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (k == 5) begin
                bus.A     = 32'h3F800000;
                bus.B     = 32'h40400000;
                bus.start = 1'b1;
            end
            if (k == 28) begin
                bus.A     = 32'hC0000000;
                bus.B     = 32'h3F000000;
                bus.start = 1'b1;
            end
            @(negedge clk);
            if (k <= 26 && bus.busy !== 1'b1) berr++;
            if (k == 27 && bus.busy !== 1'b0) berr++;
            if (bus.done) begin
                nd++;
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            if (k == 27) s27 = bus.S;
            if (k == 40) s40 = bus.S;
            if (k == 55) s55 = bus.S;
        end
        chk_i("busy window", berr, 0);
        chk_i("done count", nd, 2);
        chk_i("first done", d1, 27);
        chk_i("second done", d2, 55);
        chk("first S", s27, 32'h40400000);
        chk("S held", s40, 32'h40400000);
        chk("second S", s55, 32'hC0800000);
        @(posedge clk);
        #1 bus.start = 1'b0;

        // Reset mid-CALC, with start asserted in the same cycle.
        nd   = 0;
        berr = 0;
        bus.A     = 32'h40C00000;
        bus.B     = 32'h40000000;
        bus.start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            rst_n     = 1'b1;
            if (k == 10) begin
                rst_n     = 1'b0;
                bus.start = 1'b1;
            end
            @(negedge clk);
            if (k == 11) begin
                chk("rst busy", 32'(bus.busy), 32'd0);
                chk("rst done", 32'(bus.done), 32'd0);
                chk("rst S", bus.S, 32'd0);
            end
            if (k > 11 && bus.busy) berr++;
            if (bus.done) nd++;
        end
        chk_i("no done after rst", nd, 0);
        chk_i("idle after rst", berr, 0);
        @(posedge clk);
        #1;
        run(32'h3F800000, 32'h40400000, s, lat);
        chk("post-rst S", s, 32'h3EAAAAAA);
        chk_i("post-rst lat", lat, 27);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
